// File: rtl/denise_palette_loader.sv
// rtl/denise_palette_loader.sv - queues 24-bit palette entries and issues Denise COLORxx HI/LO register writes
// One write per 7 MHz slot; the HI write covers both nibble halves, the LO write refines the low half.
module denise_palette_loader #(
  parameter int DEPTH   = 4,
  parameter bit SKIP_LO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        bus_free,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_index,
  input  logic [23:0] in_rgb,
  output logic [7:0]  reg_address_out,
  output logic [11:0] data_out,
  output logic [2:0]  bank_out,
  output logic        loct_out,
  output logic        wr_active,
  output logic        busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [7:0]    NOP_ADDR   = 8'hFF;

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;

  logic [7:0]    fifo_index [DEPTH];
  logic [23:0]   fifo_rgb   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          pop_req;
  logic          fifo_empty;
  logic [7:0]    head_index;
  logic [23:0]   head_rgb;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cur_index;
  logic [23:0] cur_rgb;
  logic        lo_needed;

  logic [7:0]  addr_nxt;
  logic [11:0] data_nxt;
  logic [2:0]  bank_nxt;
  logic        loct_nxt;
  logic        wr_nxt;

  function automatic logic [11:0] hi_nib(input logic [23:0] rgb);
    return {rgb[23:20], rgb[15:12], rgb[7:4]};
  endfunction

  function automatic logic [11:0] lo_nib(input logic [23:0] rgb);
    return {rgb[19:16], rgb[11:8], rgb[3:0]};
  endfunction

  assign fifo_empty = (count == '0);
  assign in_ready   = (count != FULL_COUNT);
  assign push       = in_valid && in_ready;
  assign pop        = clk7_en && pop_req;
  assign head_index = fifo_index[rd_ptr];
  assign head_rgb   = fifo_rgb[rd_ptr];
  assign busy       = !fifo_empty || (state != S_IDLE);
  assign lo_needed  = !SKIP_LO || (lo_nib(cur_rgb) != hi_nib(cur_rgb));

  // Pointers rely on DEPTH being a power of two for natural wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_index[wr_ptr] <= in_index;
      fifo_rgb[wr_ptr]   <= in_rgb;
    end
  end

  always_comb begin
    state_nxt = S_IDLE;
    pop_req   = 1'b0;
    addr_nxt  = NOP_ADDR;
    data_nxt  = '0;
    bank_nxt  = '0;
    loct_nxt  = 1'b0;
    wr_nxt    = 1'b0;
    if (state == S_HI && lo_needed) begin
      // A pending LO write holds the entry for as long as the bus stays busy.
      state_nxt = S_HI;
      if (bus_free) begin
        state_nxt = S_LO;
        addr_nxt  = {3'b110, cur_index[4:0]};
        bank_nxt  = cur_index[7:5];
        data_nxt  = lo_nib(cur_rgb);
        loct_nxt  = 1'b1;
        wr_nxt    = 1'b1;
      end
    end else if (!fifo_empty && bus_free) begin
      state_nxt = S_HI;
      pop_req   = 1'b1;
      addr_nxt  = {3'b110, head_index[4:0]};
      bank_nxt  = head_index[7:5];
      data_nxt  = hi_nib(head_rgb);
      wr_nxt    = 1'b1;
    end
  end

  // Reset overrides clk7_en so a mid-sequence reset drops to NOP on the next clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      cur_index       <= '0;
      cur_rgb         <= '0;
      reg_address_out <= NOP_ADDR;
      data_out        <= '0;
      bank_out        <= '0;
      loct_out        <= 1'b0;
      wr_active       <= 1'b0;
    end else if (clk7_en) begin
      state           <= state_nxt;
      reg_address_out <= addr_nxt;
      data_out        <= data_nxt;
      bank_out        <= bank_nxt;
      loct_out        <= loct_nxt;
      wr_active       <= wr_nxt;
      if (pop_req) begin
        cur_index <= head_index;
        cur_rgb   <= head_rgb;
      end
    end
  end

endmodule
